// File: rtl/lc3_mem_pkg.sv
// Shared types and defaults for the LC3 memory responder.
// Both port FSMs and the top-level array import this package.
package lc3_mem_pkg;

    localparam int unsigned BUS_W      = 16;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_I_LAT  = 2;
    localparam int unsigned DEF_D_LAT  = 3;

    typedef logic [BUS_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/lc3_mem_responder_if.sv
// Core-to-memory bundle: fetch port, data port, backdoor preload and busy flags.
// master = core/bench side, slave = responder side.
interface lc3_mem_responder_if;
    import lc3_mem_pkg::*;

    logic  I_macc;
    logic  instrmem_rd;
    word_t pc;
    word_t Instr_dout;
    logic  complete_instr;

    logic  D_macc;
    logic  Data_rd;
    word_t Data_addr;
    word_t Data_din;
    word_t Data_dout;
    logic  complete_data;

    logic  ld_en;
    word_t ld_addr;
    word_t ld_data;

    logic  i_busy;
    logic  d_busy;

    modport master (
        output I_macc, instrmem_rd, pc,
        output D_macc, Data_rd, Data_addr, Data_din,
        output ld_en, ld_addr, ld_data,
        input  Instr_dout, complete_instr, Data_dout, complete_data,
        input  i_busy, d_busy
    );

    modport slave (
        input  I_macc, instrmem_rd, pc,
        input  D_macc, Data_rd, Data_addr, Data_din,
        input  ld_en, ld_addr, ld_data,
        output Instr_dout, complete_instr, Data_dout, complete_data,
        output i_busy, d_busy
    );

endinterface

// File: rtl/lc3_mem_port_fsm.sv
// One request port: IDLE -> WAIT (LAT cycles) -> DONE, latching the request payload
// at acceptance so later input changes are ignored until the port is idle again.
module lc3_mem_port_fsm
    import lc3_mem_pkg::*;
#(
    parameter int unsigned LAT   = 2,
    parameter int unsigned PAY_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_i,
    input  logic [PAY_W-1:0] pay_i,
    output logic             done_c_o,
    output logic             busy_o,
    output logic [PAY_W-1:0] pay_o
);

    // One spare count value keeps the width non-zero when LAT is 0.
    localparam int unsigned      CNT_W   = $clog2(LAT + 2);
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PAY_W-1:0] pay_q, pay_d;
    logic             busy_q;
    logic             accept_c;
    logic             done_c;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pay_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pay_q   <= pay_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pay_d   = pay_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    pay_d   = pay_i;
                    cnt_d   = LAT_CNT;
                    state_d = (LAT == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode; DONE lasts exactly one cycle, so done_c is a single-cycle strobe
    always_comb begin
        accept_c = 1'b0;
        done_c   = 1'b0;
        if (state_q == IDLE) begin
            accept_c = req_i;
        end
        if (state_q == DONE) begin
            done_c = 1'b1;
        end
    end

    assign done_c_o = done_c;
    assign busy_o   = busy_q;
    assign pay_o    = pay_q;

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC3 fetch and data ports over one unified word array.
// Reads sample the array before same-edge writes; a data write commit beats a preload write.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned I_LAT  = DEF_I_LAT,
    parameter int unsigned D_LAT  = DEF_D_LAT
) (
    input  logic                clock,
    input  logic                reset,
    lc3_mem_responder_if.slave  bus
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam int unsigned D_PAY_W = 1 + BUS_W + ADDR_W;

    word_t mem_q [DEPTH];

    logic [ADDR_W-1:0]  i_addr;
    logic               i_req;
    logic               i_done;
    logic               i_busy;

    logic [D_PAY_W-1:0] d_pay_in;
    logic [D_PAY_W-1:0] d_pay;
    logic               d_done;
    logic               d_busy;
    logic               d_rd;
    word_t              d_din;
    logic [ADDR_W-1:0]  d_addr;
    logic               d_wr_c;
    logic [ADDR_W-1:0]  ld_idx;

    word_t instr_dout_q;
    logic  complete_instr_q;
    word_t data_dout_q;
    logic  complete_data_q;

    assign i_req    = bus.I_macc & bus.instrmem_rd;
    assign d_pay_in = {bus.Data_rd, bus.Data_din, bus.Data_addr[ADDR_W-1:0]};

    lc3_mem_port_fsm #(
        .LAT   (I_LAT),
        .PAY_W (ADDR_W)
    ) u_i_port (
        .clock    (clock),
        .reset    (reset),
        .req_i    (i_req),
        .pay_i    (bus.pc[ADDR_W-1:0]),
        .done_c_o (i_done),
        .busy_o   (i_busy),
        .pay_o    (i_addr)
    );

    lc3_mem_port_fsm #(
        .LAT   (D_LAT),
        .PAY_W (D_PAY_W)
    ) u_d_port (
        .clock    (clock),
        .reset    (reset),
        .req_i    (bus.D_macc),
        .pay_i    (d_pay_in),
        .done_c_o (d_done),
        .busy_o   (d_busy),
        .pay_o    (d_pay)
    );

    assign d_rd   = d_pay[D_PAY_W-1];
    assign d_din  = d_pay[ADDR_W +: BUS_W];
    assign d_addr = d_pay[ADDR_W-1:0];
    assign d_wr_c = d_done & ~d_rd;
    assign ld_idx = bus.ld_addr[ADDR_W-1:0];

    // Array is never reset; the later assignment gives the data write priority over preload
    always_ff @(posedge clock) begin
        if (bus.ld_en) begin
            mem_q[ld_idx] <= bus.ld_data;
        end
        if (d_wr_c) begin
            mem_q[d_addr] <= d_din;
        end
    end

    // Response registers; read data holds between completions
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_dout_q     <= '0;
            complete_instr_q <= 1'b0;
            data_dout_q      <= '0;
            complete_data_q  <= 1'b0;
        end else begin
            complete_instr_q <= i_done;
            complete_data_q  <= d_done;
            if (i_done) begin
                instr_dout_q <= mem_q[i_addr];
            end
            if (d_done && d_rd) begin
                data_dout_q <= mem_q[d_addr];
            end
        end
    end

    assign bus.Instr_dout     = instr_dout_q;
    assign bus.complete_instr = complete_instr_q;
    assign bus.Data_dout      = data_dout_q;
    assign bus.complete_data  = complete_data_q;
    assign bus.i_busy         = i_busy;
    assign bus.d_busy         = d_busy;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Scoreboard bench for lc3_mem_responder: three instances with (I_LAT,D_LAT) = (2,3), (2,2), (0,0).
// Expected completions carry their exact cycle; a negedge monitor pops and compares them.
module tb_lc3_mem_responder;
    import lc3_mem_pkg::*;

    typedef struct {
        word_t data;
        int    cyc;
    } exp_t;

    logic  clock = 1'b0;
    logic  rst_a, rst_b, rst_c;
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    exp_t  sbq [6][$];
    word_t ddout [3];
    int    ilat [3] = '{2, 2, 0};
    int    dlat [3] = '{3, 2, 0};

    lc3_mem_responder_if ifa ();
    lc3_mem_responder_if ifb ();
    lc3_mem_responder_if ifc ();

    lc3_mem_responder #(.ADDR_W(8), .I_LAT(2), .D_LAT(3)) dut_a (
        .clock (clock), .reset (rst_a), .bus (ifa.slave));
    lc3_mem_responder #(.ADDR_W(8), .I_LAT(2), .D_LAT(2)) dut_b (
        .clock (clock), .reset (rst_b), .bus (ifb.slave));
    lc3_mem_responder #(.ADDR_W(8), .I_LAT(0), .D_LAT(0)) dut_c (
        .clock (clock), .reset (rst_c), .bus (ifc.slave));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic mon(input int q, input string tag, input logic cmpl, input word_t dout);
        exp_t e;
        if (sbq[q].size() != 0 && sbq[q][0].cyc == cyc) begin
            e = sbq[q].pop_front();
            check({tag, "_pulse"}, 16'(cmpl), 16'h1);
            check({tag, "_dout"}, dout, e.data);
        end else if (cmpl) begin
            check({tag, "_extra_pulse"}, 16'(cmpl), 16'h0);
        end
    endtask

    always @(negedge clock) begin
        mon(0, "a_instr", ifa.complete_instr, ifa.Instr_dout);
        mon(1, "a_data",  ifa.complete_data,  ifa.Data_dout);
        mon(2, "b_instr", ifb.complete_instr, ifb.Instr_dout);
        mon(3, "b_data",  ifb.complete_data,  ifb.Data_dout);
        mon(4, "c_instr", ifc.complete_instr, ifc.Instr_dout);
        mon(5, "c_data",  ifc.complete_data,  ifc.Data_dout);
    end

    task automatic drv_f(input int d, input logic en, input word_t addr);
        case (d)
            0: begin ifa.I_macc = en; ifa.instrmem_rd = en; ifa.pc = addr; end
            1: begin ifb.I_macc = en; ifb.instrmem_rd = en; ifb.pc = addr; end
            default: begin ifc.I_macc = en; ifc.instrmem_rd = en; ifc.pc = addr; end
        endcase
    endtask

    task automatic drv_d(input int d, input logic en, input logic rd, input word_t addr, input word_t din);
        case (d)
            0: begin ifa.D_macc = en; ifa.Data_rd = rd; ifa.Data_addr = addr; ifa.Data_din = din; end
            1: begin ifb.D_macc = en; ifb.Data_rd = rd; ifb.Data_addr = addr; ifb.Data_din = din; end
            default: begin ifc.D_macc = en; ifc.Data_rd = rd; ifc.Data_addr = addr; ifc.Data_din = din; end
        endcase
    endtask

    task automatic drv_ld(input int d, input logic en, input word_t addr, input word_t data);
        case (d)
            0: begin ifa.ld_en = en; ifa.ld_addr = addr; ifa.ld_data = data; end
            1: begin ifb.ld_en = en; ifb.ld_addr = addr; ifb.ld_data = data; end
            default: begin ifc.ld_en = en; ifc.ld_addr = addr; ifc.ld_data = data; end
        endcase
    endtask

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    // Advance one edge, then drop every strobe and scramble the addresses
    task automatic step();
        sync();
        for (int d = 0; d < 3; d++) begin
            drv_f(d, 1'b0, 16'hFFFF);
            drv_d(d, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
            drv_ld(d, 1'b0, 16'hFFFF, 16'h0000);
        end
    endtask

    task automatic push(input int q, input word_t data, input int at);
        exp_t e;
        e.data = data;
        e.cyc  = at;
        sbq[q].push_back(e);
    endtask

    task automatic issue_f(input int d, input word_t addr, input word_t exp);
        drv_f(d, 1'b1, addr);
        push(2 * d, exp, cyc + ilat[d] + 2);
    endtask

    // Reads expect val; writes store val and expect Data_dout to hold
    task automatic issue_d(input int d, input logic rd, input word_t addr, input word_t val);
        drv_d(d, 1'b1, rd, addr, val);
        if (rd) ddout[d] = val;
        push(2 * d + 1, ddout[d], cyc + dlat[d] + 2);
    endtask

    task automatic preload(input int d, input word_t addr, input word_t data);
        sync();
        drv_ld(d, 1'b1, addr, data);
        step();
    endtask

    function automatic bit all_idle();
        bit idle;
        idle = !(ifa.i_busy || ifa.d_busy || ifb.i_busy || ifb.d_busy || ifc.i_busy || ifc.d_busy);
        for (int q = 0; q < 6; q++) begin
            if (sbq[q].size() != 0) idle = 1'b0;
        end
        return idle;
    endfunction

    task automatic wait_done();
        int n;
        n = 0;
        while (!all_idle() && n < 60) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (n >= 60) begin
            check("idle_timeout", 16'(all_idle()), 16'h1);
            for (int q = 0; q < 6; q++) sbq[q].delete();
        end
    endtask

    // Data access whose commit edge coincides with a preload to the same address
    task automatic collide_ld(input int d, input logic rd, input word_t addr, input word_t val, input word_t ldv);
        sync();
        issue_d(d, rd, addr, val);
        step();
        repeat (dlat[d]) sync();
        drv_ld(d, 1'b1, addr, ldv);
        step();
        wait_done();
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_instr_dout"}, ifa.Instr_dout, 16'h0000);
        check({tag, "_data_dout"},  ifa.Data_dout,  16'h0000);
        check({tag, "_cmpl_i"},     16'(ifa.complete_instr), 16'h0);
        check({tag, "_cmpl_d"},     16'(ifa.complete_data),  16'h0);
        check({tag, "_i_busy"},     16'(ifa.i_busy), 16'h0);
        check({tag, "_d_busy"},     16'(ifa.d_busy), 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        for (int d = 0; d < 3; d++) begin
            drv_f(d, 1'b0, 16'h0000);
            drv_d(d, 1'b0, 1'b1, 16'h0000, 16'h0000);
            drv_ld(d, 1'b0, 16'h0000, 16'h0000);
            ddout[d] = 16'h0000;
        end
        repeat (3) @(posedge clock);
        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        check_zero_a("reset");

        // Fetch with I_LAT=2, busy visible while waiting, then a wrapped address
        preload(0, 16'h0010, 16'h1234);
        sync();
        issue_f(0, 16'h0010, 16'h1234);
        step();
        check("a_ibusy_e0", 16'(ifa.i_busy), 16'h1);
        sync();
        check("a_ibusy_e1", 16'(ifa.i_busy), 16'h1);
        wait_done();
        sync();
        issue_f(0, 16'h0110, 16'h1234);
        step();
        wait_done();

        // Held fetch request: accepted only every LAT+2 cycles
        sync();
        drv_f(0, 1'b1, 16'h0010);
        push(0, 16'h1234, cyc + 4);
        push(0, 16'h1234, cyc + 8);
        repeat (4) sync();
        step();
        wait_done();

        // Data write then read back with D_LAT=3
        sync();
        issue_d(0, 1'b0, 16'h0020, 16'hBEEF);
        step();
        wait_done();
        sync();
        issue_d(0, 1'b1, 16'h0020, 16'hBEEF);
        step();
        wait_done();

        // Data write beats a same-edge preload; data read sees the pre-preload value
        collide_ld(0, 1'b0, 16'h0050, 16'hAAAA, 16'h5555);
        sync();
        issue_d(0, 1'b1, 16'h0050, 16'hAAAA);
        step();
        wait_done();
        collide_ld(0, 1'b1, 16'h0050, 16'hAAAA, 16'h7777);
        sync();
        issue_d(0, 1'b1, 16'h0050, 16'h7777);
        step();
        wait_done();

        // Inputs changed during WAIT must not affect the accepted write
        preload(0, 16'h0061, 16'h0061);
        sync();
        issue_d(0, 1'b0, 16'h0060, 16'h6060);
        step();
        drv_d(0, 1'b0, 1'b0, 16'h0061, 16'hDEAD);
        wait_done();
        sync();
        issue_d(0, 1'b1, 16'h0060, 16'h6060);
        step();
        wait_done();
        sync();
        issue_d(0, 1'b1, 16'h0061, 16'h0061);
        step();
        wait_done();

        // Reset while a write is in WAIT abandons it
        preload(0, 16'h0040, 16'h4444);
        sync();
        issue_d(0, 1'b0, 16'h0040, 16'h9999);
        step();
        sync();
        rst_a = 1'b1;
        #1;
        check_zero_a("midrst");
        sbq[1].delete();
        ddout[0] = 16'h0000;
        repeat (2) sync();
        rst_a = 1'b0;
        repeat (6) sync();
        check("midrst_d_busy_after", 16'(ifa.d_busy), 16'h0);
        sync();
        issue_d(0, 1'b1, 16'h0040, 16'h4444);
        step();
        wait_done();

        // Same-cycle fetch and data write to one address (I_LAT=D_LAT=2)
        preload(1, 16'h0030, 16'h1111);
        sync();
        issue_f(1, 16'h0030, 16'h1111);
        issue_d(1, 1'b0, 16'h0030, 16'h2222);
        step();
        wait_done();
        sync();
        issue_f(1, 16'h0030, 16'h2222);
        step();
        wait_done();

        // Zero latency: continuous fetch pulses every 2nd cycle, with address wrap
        preload(2, 16'h0005, 16'h0505);
        sync();
        drv_f(2, 1'b1, 16'h0105);
        push(4, 16'h0505, cyc + 2);
        push(4, 16'h0505, cyc + 4);
        push(4, 16'h0505, cyc + 6);
        repeat (4) sync();
        step();
        wait_done();

        // Zero-latency data write and read
        sync();
        issue_d(2, 1'b0, 16'h0007, 16'h0707);
        step();
        wait_done();
        sync();
        issue_d(2, 1'b1, 16'h0007, 16'h0707);
        step();
        wait_done();

        repeat (3) sync();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3_mem_responder.md
Name: lc3_mem_responder

Overview:
- Memory-side responder for the LC3 core's instruction and data memory interfaces.
- Accepts fetch requests (pc, instrmem_rd, I_macc) and data requests (Data_addr, Data_rd, Data_din, D_macc).
- Returns Instr_dout/complete_instr and Data_dout/complete_data after a programmable latency.
- Holds a unified word-addressed array with a load port for program/data preload; sits opposite the core in the top-level bench and in FPGA builds.

Parameters:
- ADDR_W, 8, index bits used from 16-bit addresses; upper bits ignored, so addresses wrap modulo 2**ADDR_W.
- I_LAT, 2, cycles from fetch acceptance to complete_instr (0 allowed).
- D_LAT, 3, cycles from data acceptance to complete_data (0 allowed).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- I_macc  in  1  instruction-port access strobe.
- instrmem_rd  in  1  instruction read qualifier; a request requires I_macc=1 and instrmem_rd=1.
- pc  in  16  fetch address.
- Instr_dout  out  16  fetched instruction.
- complete_instr  out  1  one-cycle fetch completion pulse.
- D_macc  in  1  data-port access strobe.
- Data_rd  in  1  1 = read, 0 = write.
- Data_addr  in  16  data address.
- Data_din  in  16  write data from the core.
- Data_dout  out  16  read data to the core.
- complete_data  out  1  one-cycle data completion pulse.
- ld_en  in  1  backdoor preload write enable.
- ld_addr  in  16  preload address.
- ld_data  in  16  preload data.
- i_busy  out  1  instruction port not IDLE.
- d_busy  out  1  data port not IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - Both FSMs go to IDLE; counters = 0.
  - Instr_dout = 0, Data_dout = 0, complete_instr = 0, complete_data = 0, i_busy = 0, d_busy = 0.
  - Array contents are NOT cleared.
  - Reset mid-request abandons the request: no completion pulse, and no pending write commits.
- Instruction FSM, states IDLE, WAIT, DONE:
  - IDLE: when I_macc && instrmem_rd, latch pc[ADDR_W-1:0] and load counter = I_LAT. Go to DONE if I_LAT == 0, else WAIT.
  - WAIT: decrement counter each cycle; on reaching 0 go to DONE.
  - DONE: register Instr_dout = mem[latched addr] and pulse complete_instr = 1 for exactly one cycle, then go to IDLE.
  - Latency: complete_instr is high I_LAT+1 cycles after the acceptance edge.
- Data FSM, states IDLE, WAIT, DONE:
  - Same structure and timing as the instruction FSM, using D_macc and D_LAT.
  - At acceptance, latch Data_addr, Data_rd and Data_din.
  - DONE, read: Data_dout = mem[addr].
  - DONE, write: mem[addr] <= latched Data_din; Data_dout holds its previous value.
  - complete_data pulses for one cycle in both cases.
- Input changes after acceptance are ignored until the port returns to IDLE.
- No new request is accepted in the DONE cycle. Earliest back-to-back acceptance is the cycle after the completion pulse, so throughput is one request per LAT+2 cycles per port.
- Instr_dout and Data_dout hold their last value between completions.
- The two ports are fully independent and may complete in the same cycle.
- Same-address collisions in one cycle:
  - Instruction read vs data write commit: read returns the old value (read-before-write). The same rule applies to a data read vs ld_en.
  - Data write commit vs ld_en: the data write wins.
- ld_en writes mem[ld_addr[ADDR_W-1:0]] <= ld_data on the edge; it is legal in any FSM state.
- Address wrap: pc = 16'h0105 with ADDR_W = 8 accesses word 8'h05.

Decomposition:
- Shared package lc3_mem_pkg:
  - typedef enum mem_state_t {IDLE, WAIT, DONE}.
  - typedef logic [15:0] word_t.
  - Localparams for default latencies.
- One natural sub-module, lc3_mem_port_fsm, parameterised by LAT. It is instantiated twice (instruction and data) and provides accept/busy/done signals plus the latched address.
- The array and collision priority logic stay in the top module.

Test Plan:
- Preload mem[0x10] = 0x1234 via ld_en; I_macc = instrmem_rd = 1, pc = 0x0010 for one cycle -> complete_instr high exactly 3 cycles later, Instr_dout = 0x1234, i_busy high in between.
- Data write 0xBEEF to 0x20 (D_macc = 1, Data_rd = 0), then read 0x20 after completion -> second complete_data 4 cycles after its acceptance, Data_dout = 0xBEEF.
- Simultaneous fetch of 0x30 (preloaded 0x1111) and data write 0x2222 to 0x30 with I_LAT = D_LAT = 2, completing the same cycle -> Instr_dout = 0x1111; a later fetch of 0x30 returns 0x2222.
- Assert reset while data write to 0x40 is in WAIT -> no complete_data pulse, mem[0x40] unchanged, all outputs 0, i_busy = d_busy = 0.
- I_LAT = 0: request held high continuously -> complete_instr pulses every 2nd cycle; pc = 0x0105 returns mem[0x05] (wrap).
- Change Data_addr and Data_din during WAIT -> the completed access uses the values latched at acceptance.
